// File: rtl/z80_memmap_decoder_if.sv
// ---------------------------------------------------------------------------
// z80_memmap_decoder_if
// Bus bundle between a Z80-side driver and the memory-map decoder.
//   cen       : Z80-rate clock enable (driver -> decoder)
//   mreq_n    : Z80 MREQ, active low (driver -> decoder)
//   rfsh_n    : Z80 RFSH, active low (driver -> decoder)
//   addr      : Z80 address bus (driver -> decoder)
//   enable_n  : video-chip bus grant, active low (driver -> decoder)
//   cs_n      : chip selects, active low (decoder -> driver)
//   wait_n    : Z80 WAIT, active low (decoder -> driver)
//   multi_hit : one-clk pulse on overlapping decode (decoder -> driver)
// ---------------------------------------------------------------------------
interface z80_memmap_decoder_if #(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 8
);
  logic                   cen;
  logic                   mreq_n;
  logic                   rfsh_n;
  logic [ADDR_W-1:0]      addr;
  logic                   enable_n;
  logic [NUM_REGIONS-1:0] cs_n;
  logic                   wait_n;
  logic                   multi_hit;

  modport master (
    output cen, mreq_n, rfsh_n, addr, enable_n,
    input  cs_n, wait_n, multi_hit
  );

  modport slave (
    input  cen, mreq_n, rfsh_n, addr, enable_n,
    output cs_n, wait_n, multi_hit
  );
endinterface

// File: rtl/z80_memmap_decoder.sv
// ---------------------------------------------------------------------------
// z80_memmap_decoder
// Decodes Z80 memory cycles into per-region chip selects with optional
// wait-state insertion. A decode is taken on the first cen cycle that sees
// MREQ low after it was high (refresh cycles excluded); the winning region
// is captured there and held until MREQ is released.
// Ports:
//   clk   : system clock (only clock)
//   reset : synchronous active-high reset, honoured regardless of cen
//   bus   : z80_memmap_decoder_if.slave (cen, mreq_n, rfsh_n, addr,
//           enable_n in; cs_n, wait_n, multi_hit out, all registered)
// ---------------------------------------------------------------------------
module z80_memmap_decoder #(
  parameter int ADDR_W      = 16,
  parameter int NUM_REGIONS = 8,
  parameter int WS_W        = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {16'hC000, 16'hB400, 16'hB000, 16'hA000, 16'h6000, 16'h4000, 16'h2000, 16'h0000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {16'hE000, 16'hF400, 16'hF400, 16'hF000, 16'hE000, 16'hE000, 16'hE000, 16'hE000},
  parameter logic [NUM_REGIONS*WS_W-1:0] REGION_WS =
    {2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0},
  parameter logic [NUM_REGIONS-1:0] REGION_GATED = 8'b0111_0000
) (
  input logic                 clk,
  input logic                 reset,
  z80_memmap_decoder_if.slave bus
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
  localparam logic [NUM_REGIONS-1:0] CS_IDLE = {NUM_REGIONS{1'b1}};
  localparam logic [NUM_REGIONS-1:0] LSB_ONE = NUM_REGIONS'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_MISS   = 2'd3
  } state_t;

  state_t                 state_q;
  logic                   mreq_prev_q;  // mreq_n as seen on the last cen cycle
  logic                   armed_q;      // set once mreq_n has been seen high since reset
  logic [WS_W-1:0]        cnt_q;
  logic [IDX_W-1:0]       win_q;
  logic [NUM_REGIONS-1:0] cs_n_q;
  logic                   wait_n_q;
  logic                   multi_hit_q;

  logic [NUM_REGIONS-1:0] match_s;
  logic [IDX_W-1:0]       win_idx_s;
  logic [WS_W-1:0]        win_ws_s;
  logic                   any_s;
  logic                   multi_s;
  logic                   trigger_s;

  // Active-low select vector with only the given region asserted.
  function automatic logic [NUM_REGIONS-1:0] cs_for(input logic [IDX_W-1:0] idx);
    return ~(LSB_ONE << idx);
  endfunction

  // Per-region address/grant match against the live bus.
  always_comb begin
    match_s = {NUM_REGIONS{1'b0}};
    for (int i = 0; i < NUM_REGIONS; i++) begin
      match_s[i] = ((bus.addr & REGION_MASK[i*ADDR_W +: ADDR_W]) ==
                    (REGION_BASE[i*ADDR_W +: ADDR_W] & REGION_MASK[i*ADDR_W +: ADDR_W])) &&
                   (!REGION_GATED[i] || !bus.enable_n);
    end
  end

  // Lowest-index match wins; scan from the top so lower indices overwrite.
  always_comb begin
    win_idx_s = {IDX_W{1'b0}};
    win_ws_s  = {WS_W{1'b0}};
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      win_idx_s = match_s[i] ? IDX_W'(i) : win_idx_s;
      win_ws_s  = match_s[i] ? REGION_WS[i*WS_W +: WS_W] : win_ws_s;
    end
  end

  assign any_s   = |match_s;
  // Clearing the lowest set bit leaves something only if two or more matched.
  assign multi_s = |(match_s & (match_s - LSB_ONE));
  // Falling MREQ edge outside refresh; armed_q blocks a cycle already in
  // progress when reset releases.
  assign trigger_s = armed_q && mreq_prev_q && !bus.mreq_n && bus.rfsh_n;

  // Bus-cycle FSM with registered chip selects, WAIT and overlap pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mreq_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      cnt_q       <= {WS_W{1'b0}};
      win_q       <= {IDX_W{1'b0}};
      cs_n_q      <= CS_IDLE;
      wait_n_q    <= 1'b1;
      multi_hit_q <= 1'b0;
    end else begin
      multi_hit_q <= 1'b0;
      if (bus.cen) begin
        mreq_prev_q <= bus.mreq_n;
        if (bus.mreq_n) begin
          armed_q <= 1'b1;
        end
        case (state_q)
          S_IDLE: begin
            if (trigger_s) begin
              // Only the winner is kept; address and grant are not
              // consulted again for the rest of the bus cycle.
              win_q       <= win_idx_s;
              multi_hit_q <= multi_s;
              if (!any_s) begin
                state_q <= S_MISS;
              end else if (win_ws_s != {WS_W{1'b0}}) begin
                state_q  <= S_WAIT;
                cnt_q    <= win_ws_s;
                cs_n_q   <= cs_for(win_idx_s);
                wait_n_q <= 1'b0;
              end else begin
                state_q <= S_ACTIVE;
                cs_n_q  <= cs_for(win_idx_s);
              end
            end
          end
          S_WAIT: begin
            // MREQ release is deliberately not looked at until WAIT ends.
            if (cnt_q <= WS_W'(1'b1)) begin
              state_q  <= S_ACTIVE;
              cnt_q    <= {WS_W{1'b0}};
              cs_n_q   <= cs_for(win_q);
              wait_n_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - WS_W'(1'b1);
            end
          end
          S_ACTIVE: begin
            if (bus.mreq_n) begin
              state_q <= S_IDLE;
              cs_n_q  <= CS_IDLE;
            end
          end
          S_MISS: begin
            if (bus.mreq_n) begin
              state_q <= S_IDLE;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            cs_n_q   <= CS_IDLE;
            wait_n_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.cs_n      = cs_n_q;
  assign bus.wait_n    = wait_n_q;
  assign bus.multi_hit = multi_hit_q;

endmodule

// File: tb/tb_z80_memmap_decoder.sv
// ---------------------------------------------------------------------------
// tb_z80_memmap_decoder
// Two decoders share one stimulus stream: dut0 with the default map, dut1
// with region 1 moved to 0000h so low addresses hit two regions. Each clock
// the stimulus pushes the outputs it expects after that edge; a monitor on
// the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_z80_memmap_decoder;

  typedef struct packed {
    logic [7:0] cs;
    logic       w;
    logic       m;
  } exp_t;

  localparam logic [15:0] BASE_T [8] = '{16'h0000, 16'h2000, 16'h4000, 16'h6000,
                                         16'hA000, 16'hB000, 16'hB400, 16'hC000};
  localparam logic [15:0] MASK_T [8] = '{16'hE000, 16'hE000, 16'hE000, 16'hE000,
                                         16'hF000, 16'hF400, 16'hF400, 16'hE000};
  localparam int   WS_T    [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
  localparam bit   GATED_T [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  z80_memmap_decoder_if #(.ADDR_W(16), .NUM_REGIONS(8)) bus0 ();
  z80_memmap_decoder_if #(.ADDR_W(16), .NUM_REGIONS(8)) bus1 ();

  assign bus1.cen      = bus0.cen;
  assign bus1.mreq_n   = bus0.mreq_n;
  assign bus1.rfsh_n   = bus0.rfsh_n;
  assign bus1.addr     = bus0.addr;
  assign bus1.enable_n = bus0.enable_n;

  z80_memmap_decoder dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

  z80_memmap_decoder #(
    .REGION_BASE({16'hC000, 16'hB400, 16'hB000, 16'hA000,
                  16'h6000, 16'h4000, 16'h0000, 16'h0000})
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

  exp_t q0 [$];
  exp_t q1 [$];
  logic [7:0] e_cs [2];
  logic       e_w  [2];
  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  function automatic bit gen_cen(input int prob);
    return ($urandom_range(99, 0) < prob);
  endfunction

  function automatic logic [7:0] sel_cs(input int w);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << w);
  endfunction

  // Region rule applied literally: masked compare, gate on grant, lowest wins.
  function automatic void ref_decode(input int d, input logic [15:0] a, input logic en,
                                     output int win, output int nm);
    logic [15:0] b;
    win = -1;
    nm  = 0;
    for (int i = 0; i < 8; i++) begin
      b = (d == 1 && i == 1) ? 16'h0000 : BASE_T[i];
      if (((a & MASK_T[i]) == (b & MASK_T[i])) && (!GATED_T[i] || !en)) begin
        nm++;
        if (win < 0) win = i;
      end
    end
  endfunction

  task automatic tick(input bit c, input bit m0, input bit m1);
    exp_t r;
    bus0.cen = c;
    @(posedge clk);
    r.cs = e_cs[0]; r.w = e_w[0]; r.m = m0; q0.push_back(r);
    r.cs = e_cs[1]; r.w = e_w[1]; r.m = m1; q1.push_back(r);
    #1;
  endtask

  // One Z80 memory cycle: falling MREQ, hold for some cen cycles, release.
  task automatic run_cycle(input logic [15:0] a, input logic en, input logic rf,
                           input int hold, input int prob, input bit mutate);
    int win [2];
    int nm  [2];
    int ws  [2];
    bit ex  [2];
    bit mh  [2];
    bit c;
    int k, idle_run, n_pre, h;
    bus0.mreq_n = 1'b1;
    bus0.rfsh_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    n_pre = $urandom_range(2, 0);
    for (int i = 0; i < n_pre; i++) tick(gen_cen(prob), 1'b0, 1'b0);
    bus0.addr = a; bus0.enable_n = en; bus0.rfsh_n = rf; bus0.mreq_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ref_decode(d, a, en, win[d], nm[d]);
      ws[d] = (win[d] >= 0) ? WS_T[win[d]] : 0;
      ex[d] = 1'b0;
    end
    c = 1'b0;
    idle_run = 0;
    while (!c) begin
      c = gen_cen(prob) || (idle_run >= 5);
      idle_run++;
      for (int d = 0; d < 2; d++) begin
        mh[d] = c && rf && (nm[d] >= 2);
        if (c && rf && (win[d] >= 0)) begin
          e_cs[d] = sel_cs(win[d]);
          e_w[d]  = (ws[d] == 0);
        end
      end
      tick(c, mh[0], mh[1]);
    end
    k = 0; h = 0; idle_run = 0;
    while (h < hold) begin
      c = gen_cen(prob) || (idle_run >= 5);
      idle_run = c ? 0 : idle_run + 1;
      if (mutate) begin
        bus0.addr = 16'($urandom);
        bus0.enable_n = 1'($urandom_range(1, 0));
      end
      if (c) begin
        k++; h++;
        for (int d = 0; d < 2; d++)
          if (rf && win[d] >= 0) e_w[d] = (k >= ws[d]);
      end
      tick(c, 1'b0, 1'b0);
    end
    bus0.mreq_n = 1'b1;
    bus0.rfsh_n = 1'b1;
    idle_run = 0;
    while (!(ex[0] && ex[1])) begin
      c = gen_cen(prob) || (idle_run >= 5);
      idle_run = c ? 0 : idle_run + 1;
      if (mutate) bus0.addr = 16'($urandom);
      if (c) begin
        k++;
        for (int d = 0; d < 2; d++) begin
          if (!ex[d]) begin
            if (!rf || win[d] < 0 || k > ws[d]) begin
              ex[d] = 1'b1; e_cs[d] = 8'hFF; e_w[d] = 1'b1;
            end else begin
              e_w[d] = (k >= ws[d]);
            end
          end
        end
      end
      tick(c, 1'b0, 1'b0);
    end
  endtask

  // Reset while a C000h access sits in WAIT, MREQ held low throughout.
  task automatic reset_in_wait();
    bus0.mreq_n = 1'b1; bus0.rfsh_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
    bus0.addr = 16'hC000; bus0.enable_n = 1'b1; bus0.mreq_n = 1'b0;
    e_cs = '{8'h7F, 8'h7F}; e_w = '{1'b0, 1'b0};
    tick(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    e_cs = '{8'hFF, 8'hFF}; e_w = '{1'b1, 1'b1};
    tick(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    bus0.mreq_n = 1'b1;
    tick(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: compare both decoders against the expectation for this cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      check("dut0_cs_n", bus0.cs_n, e.cs);
      check("dut0_wait_n", {7'd0, bus0.wait_n}, {7'd0, e.w});
      check("dut0_multi_hit", {7'd0, bus0.multi_hit}, {7'd0, e.m});
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("dut1_cs_n", bus1.cs_n, e.cs);
      check("dut1_wait_n", {7'd0, bus1.wait_n}, {7'd0, e.w});
      check("dut1_multi_hit", {7'd0, bus1.multi_hit}, {7'd0, e.m});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    reset = 1'b1;
    bus0.cen = 1'b0; bus0.mreq_n = 1'b1; bus0.rfsh_n = 1'b1;
    bus0.addr = 16'h0000; bus0.enable_n = 1'b1;
    e_cs = '{8'hFF, 8'hFF}; e_w = '{1'b1, 1'b1};
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    reset = 1'b0;

    run_cycle(16'h2345, 1'b1, 1'b1, 2, 100, 1'b0);
    run_cycle(16'hB400, 1'b1, 1'b1, 2, 100, 1'b0);
    run_cycle(16'hB400, 1'b0, 1'b1, 2, 100, 1'b0);
    run_cycle(16'hC000, 1'b1, 1'b1, 3, 100, 1'b0);
    run_cycle(16'hC000, 1'b1, 1'b1, 0, 100, 1'b0);
    run_cycle(16'h0000, 1'b1, 1'b0, 2, 100, 1'b0);
    run_cycle(16'h0100, 1'b1, 1'b1, 1, 100, 1'b0);
    reset_in_wait();
    run_cycle(16'hA123, 1'b0, 1'b1, 1, 100, 1'b0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(1, 0) == 1) a = 16'($urandom);
      else a = BASE_T[$urandom_range(7, 0)] + 16'($urandom_range(15, 0));
      run_cycle(a, 1'($urandom_range(1, 0)),
                ($urandom_range(9, 0) != 0),
                $urandom_range(4, 0),
                ($urandom_range(1, 0) == 1) ? 100 : 50,
                1'b1);
    end

    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
